rom_image_loader: RTL and testbench



---
 rtl/rom_image_loader.sv | 110 +++++++++++
 tb/tb_rom_image_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_image_loader.sv
// rom_image_loader: streams bytes from a valid/ready source into a block RAM.
// Bytes are packed little-endian into RAM_WIDTH-bit words and written from
// address 0 upward. busy/done and an 8-bit additive checksum let the system
// controller validate the image before releasing the CPU.
module rom_image_loader #(
  parameter int RAM_WIDTH = 18,
  parameter int RAM_DEPTH = 1024,
  localparam int BPW = (RAM_WIDTH + 7) / 8,
  localparam int AW  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 wea,
  output logic [AW-1:0]        addra_w,
  output logic [RAM_WIDTH-1:0] dina,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           checksum
);

  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]           state;
  logic [BCW-1:0]       byte_cnt;
  logic [RAM_WIDTH-1:0] asm_word;
  logic [RAM_WIDTH-1:0] asm_next;
  logic                 xfer;
  logic                 last_byte;
  logic                 last_word;

  // Status and handshake outputs decode directly from the state register.
  assign s_ready   = (state == COLLECT);
  assign busy      = (state == COLLECT) || (state == WRITE);
  assign done      = (state == DONE);
  assign xfer      = s_valid && s_ready;
  assign last_byte = (byte_cnt == BCW'(BPW - 1));
  assign last_word = (addra_w == AW'(RAM_DEPTH - 1));

  // Merge the incoming byte into its lane; bits past RAM_WIDTH-1 fall away.
  for (genvar b = 0; b < RAM_WIDTH; b++) begin : g_lane
    assign asm_next[b] = (byte_cnt == BCW'(b / 8)) ? s_data[b % 8] : asm_word[b];
  end

  // Load sequencing, word assembly, write port and checksum.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state    <= IDLE;
      byte_cnt <= '0;
      asm_word <= '0;
      addra_w  <= '0;
      dina     <= '0;
      wea      <= 1'b0;
      checksum <= '0;
    end else begin
      wea <= 1'b0;
      if (xfer) begin
        checksum <= checksum + s_data;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= COLLECT;
            checksum <= '0;
            byte_cnt <= '0;
            addra_w  <= '0;
            asm_word <= '0;
          end
        end
        COLLECT: begin
          if (abort) begin
            state <= IDLE;
          end else if (xfer) begin
            if (last_byte) begin
              dina     <= asm_next;
              wea      <= 1'b1;
              byte_cnt <= '0;
              asm_word <= '0;
              state    <= WRITE;
            end else begin
              asm_word <= asm_next;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            state <= IDLE;
          end else if (last_word) begin
            state <= DONE;
          end else begin
            addra_w <= addra_w + 1'b1;
            state   <= COLLECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_image_loader.sv
// Directed-sequence bench for rom_image_loader with a byte-list reference model.
module tb_rom_image_loader;

  localparam int RW  = 18;
  localparam int RD  = 4;
  localparam int BPW = (RW + 7) / 8;
  localparam int AW  = 2;
  localparam int NB  = BPW * RD;

  logic          clka = 1'b0;
  logic          rsta_n, start, abort, s_valid;
  logic [7:0]    s_data;
  logic          s_ready, wea, busy, done;
  logic [AW-1:0] addra_w;
  logic [RW-1:0] dina;
  logic [7:0]    checksum;

  rom_image_loader #(.RAM_WIDTH(RW), .RAM_DEPTH(RD)) dut (
    .clka(clka), .rsta_n(rsta_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wea(wea), .addra_w(addra_w), .dina(dina),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clka = ~clka;

  int unsigned   cyc = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [RW-1:0] wr_data_q[$];
  int unsigned   wr_cyc_q[$];
  logic [7:0]    bytes[$];
  int            checks = 0;
  int            passed = 0;
  int            fails  = 0;

  always @(posedge clka) cyc <= cyc + 1;

  // Log every write presented to the memory.
  always @(posedge clka) begin
    if (wea) begin
      wr_addr_q.push_back(addra_w);
      wr_data_q.push_back(dina);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Word w is bytes w*BPW.. placed little-endian, truncated to RW bits.
  function automatic logic [RW-1:0] model_word(input int w);
    logic [63:0] acc = '0;
    for (int k = 0; k < BPW; k++) acc += 64'(bytes[w*BPW+k]) << (8 * k);
    return acc[RW-1:0];
  endfunction

  function automatic logic [7:0] model_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(bytes[i]);
    return 8'(s % 256);
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
  endtask

  // Offer bytes[from..to_excl-1] with up to gap_max idle cycles before each.
  task automatic send_range(input int from, input int to_excl, input int gap_max);
    for (int i = from; i < to_excl; i++) begin
      int  tries = 0;
      bit  acc   = 1'b0;
      if (gap_max > 0) begin
        int g = int'($urandom_range(gap_max, 0));
        s_valid = 1'b0;
        repeat (g) begin @(posedge clka); #1; end
      end
      s_valid = 1'b1;
      s_data  = bytes[i];
      while (!acc && tries < 20) begin
        @(posedge clka);
        acc = s_ready;
        tries++;
        #1;
      end
      if (!acc) begin
        check("accept_timeout", 64'(acc), 64'd1);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin @(posedge clka); #1; n++; end
    check("done_wait", 64'(done), 64'd1);
  endtask

  task automatic run_load(input int gap_max);
    clear_log();
    pulse_start();
    check("load_busy", 64'(busy), 64'd1);
    check("load_sum_clr", 64'(checksum), 64'd0);
    send_range(0, NB, gap_max);
    wait_done();
  endtask

  task automatic check_image(input string tag, input bit timing);
    check({tag, "_nwr"}, 64'(wr_data_q.size()), 64'(RD));
    for (int w = 0; w < RD && w < wr_data_q.size(); w++) begin
      check({tag, "_addr"}, 64'(wr_addr_q[w]), 64'(w));
      check({tag, "_data"}, 64'(wr_data_q[w]), 64'(model_word(w)));
      if (timing && w > 0)
        check({tag, "_rate"}, 64'(wr_cyc_q[w] - wr_cyc_q[w-1]), 64'(BPW + 1));
    end
    check({tag, "_sum"}, 64'(checksum), 64'(model_sum(NB)));
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rsta_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b1; s_data = 8'hA5;

    // Reset with the stream offering data.
    repeat (3) @(posedge clka); #1;
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_wea", 64'(wea), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_addr", 64'(addra_w), 64'd0);
    check("rst_dina", 64'(dina), 64'd0);
    check("rst_sum", 64'(checksum), 64'd0);
    rsta_n = 1'b1;
    repeat (3) begin @(posedge clka); #1; check("idle_ready", 64'(s_ready), 64'd0); end
    check("idle_sum", 64'(checksum), 64'd0);
    s_valid = 1'b0;

    // Single word assembly, then abort during its WRITE cycle.
    bytes = '{8'h34, 8'h12, 8'hFF};
    clear_log();
    pulse_start();
    check("asm_busy", 64'(busy), 64'd1);
    send_range(0, 3, 0);
    check("asm_wea", 64'(wea), 64'd1);
    check("asm_addr", 64'(addra_w), 64'd0);
    check("asm_dina", 64'(dina), 64'h31234);
    check("asm_sum", 64'(checksum), 64'h45);
    check("asm_ready", 64'(s_ready), 64'd0);
    abort = 1'b1;
    @(posedge clka); #1;
    abort = 1'b0;
    check("abw_wea", 64'(wea), 64'd0);
    check("abw_busy", 64'(busy), 64'd0);
    check("abw_done", 64'(done), 64'd0);
    check("abw_sum", 64'(checksum), 64'h45);
    repeat (3) begin @(posedge clka); #1; end
    check("abw_nwr", 64'(wr_data_q.size()), 64'd1);

    // Full load of an incrementing pattern, back-to-back.
    bytes.delete();
    for (int i = 0; i < NB; i++) bytes.push_back(8'(i + 1));
    run_load(0);
    check_image("seq", 1'b1);
    s_valid = 1'b1;
    s_data  = 8'h0D;
    repeat (4) begin
      @(posedge clka);
      check("done_ready", 64'(s_ready), 64'd0);
      #1;
    end
    s_valid = 1'b0;
    check("done_hold", 64'(done), 64'd1);
    check("done_sum", 64'(checksum), 64'h4E);
    check("done_nwr", 64'(wr_data_q.size()), 64'(RD));

    // Random image, back-to-back then with random gaps.
    bytes.delete();
    for (int i = 0; i < NB; i++) bytes.push_back(8'($urandom));
    run_load(0);
    check_image("rnd_b2b", 1'b1);
    run_load(3);
    check_image("rnd_gap", 1'b0);

    // Abort two bytes into word 1.
    clear_log();
    pulse_start();
    send_range(0, BPW + 2, 1);
    abort = 1'b1;
    @(posedge clka); #1;
    abort = 1'b0;
    check("abc_busy", 64'(busy), 64'd0);
    check("abc_done", 64'(done), 64'd0);
    check("abc_sum", 64'(checksum), 64'(model_sum(BPW + 2)));
    repeat (5) begin @(posedge clka); #1; end
    check("abc_nwr", 64'(wr_data_q.size()), 64'd1);

    // start+abort together while idle: start wins, reload from address 0.
    clear_log();
    start = 1'b1; abort = 1'b1;
    @(posedge clka); #1;
    start = 1'b0; abort = 1'b0;
    check("sa_idle_busy", 64'(busy), 64'd1);
    check("sa_idle_sum", 64'(checksum), 64'd0);
    send_range(0, NB, 2);
    wait_done();
    check_image("reload", 1'b0);

    // start+abort together while busy: abort wins.
    pulse_start();
    start = 1'b1; abort = 1'b1;
    @(posedge clka); #1;
    start = 1'b0; abort = 1'b0;
    check("sa_busy_busy", 64'(busy), 64'd0);
    check("sa_busy_done", 64'(done), 64'd0);

    // Reset landing on the WRITE cycle of word 2.
    clear_log();
    pulse_start();
    send_range(0, 3 * BPW, 0);
    check("rw_wea", 64'(wea), 64'd1);
    check("rw_addr", 64'(addra_w), 64'd2);
    rsta_n = 1'b0;
    @(posedge clka); #1;
    check("rw_wea_off", 64'(wea), 64'd0);
    check("rw_busy", 64'(busy), 64'd0);
    check("rw_done", 64'(done), 64'd0);
    check("rw_ready", 64'(s_ready), 64'd0);
    check("rw_addr0", 64'(addra_w), 64'd0);
    check("rw_dina0", 64'(dina), 64'd0);
    check("rw_sum0", 64'(checksum), 64'd0);
    rsta_n = 1'b1;
    repeat (2) begin @(posedge clka); #1; end
    check("rw_idle_ready", 64'(s_ready), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
